// File: rtl/layer_3_scan_controller.sv
// Nested x/y/temp scan sequencer with ready back-pressure for the layer-3 datapath.
// Optional early termination via the abort port when SCAN_ABORT_EN is defined.
`timescale 1ns/1ps
module layer_3_scan_controller #(
  parameter int X_LAST = 29,
  parameter int Y_LAST = 29,
  parameter int T_LAST = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       ready,
`ifdef SCAN_ABORT_EN
  input  logic       abort,
`endif
  output logic       busy,
  output logic       valid,
  output logic [4:0] x,
  output logic [4:0] y,
  output logic [3:0] temp,
  output logic       temp_zero,
  output logic       y_zero,
  output logic       x_zero,
  output logic       done
);

  localparam logic [4:0] XL = 5'(X_LAST);
  localparam logic [4:0] YL = 5'(Y_LAST);
  localparam logic [3:0] TL = 4'(T_LAST);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t     state, state_nxt;
  logic [4:0] x_nxt, y_nxt;
  logic [3:0] temp_nxt;

  assign valid     = (state == RUN);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign temp_zero = valid && (temp == TL);
  assign y_zero    = temp_zero && (y == YL);
  assign x_zero    = y_zero && (x == XL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      x     <= '0;
      y     <= '0;
      temp  <= '0;
    end else begin
      state <= state_nxt;
      x     <= x_nxt;
      y     <= y_nxt;
      temp  <= temp_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    x_nxt     = x;
    y_nxt     = y;
    temp_nxt  = temp;
    case (state)
      IDLE: begin
        // Counters are already zero here; clearing keeps IDLE outputs pinned.
        x_nxt    = '0;
        y_nxt    = '0;
        temp_nxt = '0;
        if (start) state_nxt = RUN;
      end
      RUN: begin
`ifdef SCAN_ABORT_EN
        if (abort) begin
          state_nxt = IDLE;
          x_nxt     = '0;
          y_nxt     = '0;
          temp_nxt  = '0;
        end else
`endif
        if (ready) begin
          if (x_zero) begin
            state_nxt = DONE;
            x_nxt     = '0;
            y_nxt     = '0;
            temp_nxt  = '0;
          end else if (temp_zero) begin
            temp_nxt = '0;
            if (y_zero) begin
              y_nxt = '0;
              x_nxt = x + 5'd1;
            end else begin
              y_nxt = y + 5'd1;
            end
          end else begin
            temp_nxt = temp + 4'd1;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_layer_3_scan_controller.sv
// Scoreboard bench: driver queues expected beats from an index-based model, monitor checks accepted beats.
`timescale 1ns/1ps
module tb_layer_3_scan_controller;
  localparam int XL = 29, YL = 29, TL = 8;
  localparam int NT = TL + 1, NY = YL + 1, NX = XL + 1;
  localparam int TOTAL = NT * NY * NX;

  logic clk = 1'b0;
  logic rst, start, ready, abort;
  logic busy, valid, temp_zero, y_zero, x_zero, done;
  logic [4:0] x, y;
  logic [3:0] temp;

  typedef struct {
    int x; int y; int t;
    bit tz; bit yz; bit xz; bit last;
  } beat_t;

  beat_t exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  layer_3_scan_controller #(.X_LAST(XL), .Y_LAST(YL), .T_LAST(TL)) dut (
    .clk(clk), .rst(rst), .start(start), .ready(ready),
`ifdef SCAN_ABORT_EN
    .abort(abort),
`endif
    .busy(busy), .valid(valid), .x(x), .y(y), .temp(temp),
    .temp_zero(temp_zero), .y_zero(y_zero), .x_zero(x_zero), .done(done)
  );

  always #5 clk = ~clk;

  // Beat n of a scan, derived from its linear position (temp fastest, x slowest).
  function automatic beat_t model(input int n);
    beat_t b;
    b.t    = n % NT;
    b.y    = (n / NT) % NY;
    b.x    = n / (NT * NY);
    b.tz   = (b.t == TL);
    b.yz   = b.tz && (b.y == YL);
    b.xz   = b.yz && (b.x == XL);
    b.last = (n == TOTAL - 1);
    return b;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_range(input int lo, input int hi);
    for (int n = lo; n <= hi; n++) exp_q.push_back(model(n));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string name);
    check({name, "_busy"},  busy,  0);
    check({name, "_valid"}, valid, 0);
    check({name, "_done"},  done,  0);
    check({name, "_xyt"},   {x, y, temp}, 0);
    check({name, "_queue"}, exp_q.size(), 0);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("first_beat_valid", valid, 1);
    check("first_beat_xyt", {x, y, temp}, 0);
  endtask

  task automatic wait_done(input int bound, input bit rand_ready);
    int k = 0;
    while (!done && k < bound) begin
      if (rand_ready) ready = 1'($urandom_range(0, 1));
      tick();
      k++;
    end
    ready = 1'b1;
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: no done within %0d cycles", bound);
    end
  endtask

  // Monitor: compares every accepted beat, hold stability and done timing.
  initial begin
    logic [16:0] prev;
    bit hold_prev, pend_done;
    beat_t b;
    hold_prev = 0;
    pend_done = 0;
    prev = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_prev = 0;
        pend_done = 0;
      end else begin
        check("done_timing", done, pend_done);
        pend_done = 0;
        if (done) check("done_busy_valid", {busy, valid}, 2'b10);
        if (hold_prev) check("hold_stable", {x, y, temp, temp_zero, y_zero, x_zero}, prev);
        if (!valid) check("flags_invalid", {temp_zero, y_zero, x_zero}, 0);
        if (valid && ready && !abort) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL beat_extra: got beat (%0d,%0d,%0d) expected none", x, y, temp);
          end else begin
            b = exp_q.pop_front();
            check("beat", {busy, x, y, temp, temp_zero, y_zero, x_zero},
                  {1'b1, 5'(b.x), 5'(b.y), 4'(b.t), b.tz, b.yz, b.xz});
            pend_done = b.last;
          end
        end
        hold_prev = valid && !ready && !abort;
        prev = {x, y, temp, temp_zero, y_zero, x_zero};
      end
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; ready = 1'b1; abort = 1'b0;
    repeat (3) tick();
    check_idle("reset");
    rst = 1'b0;
    tick();
    check_idle("post_reset");

    // Full scan, ready held high; start pulse seen in DONE is ignored.
    push_range(0, TOTAL - 1);
    do_start();
    wait_done(TOTAL + 10, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_idle("after_scan1");
    repeat (3) tick();
    check_idle("start_in_done_ignored");

    // Random back-pressure.
    push_range(0, TOTAL - 1);
    do_start();
    wait_done(TOTAL * 12, 1);
    tick();
    check_idle("after_scan2");

    // Start pulses during RUN must not disturb the sequence.
    push_range(0, TOTAL - 1);
    do_start();
    for (int i = 0; i < 5; i++) begin
      repeat (97) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    wait_done(TOTAL + 10, 0);
    tick();
    check_idle("after_scan3");

    // Reset mid-scan at beat (5,3,2).
    push_range(0, 5 * NT * NY + 3 * NT + 2 - 1);
    do_start();
    repeat (5 * NT * NY + 3 * NT + 2) tick();
    check("beat_532", {x, y, temp}, {5'd5, 5'd3, 4'd2});
    rst = 1'b1;
    #1;
    check_idle("async_reset");
    tick();
    rst = 1'b0;
    repeat (4) tick();
    check_idle("after_mid_reset");
    push_range(0, TOTAL - 1);
    do_start();
    wait_done(TOTAL + 10, 0);
    tick();
    check_idle("after_scan4");

`ifdef SCAN_ABORT_EN
    // abort is ignored in IDLE; abort at (10,0,4) then at the final beat.
    push_range(0, 10 * NT * NY + 4 - 1);
    abort = 1'b1;
    do_start();
    abort = 1'b0;
    repeat (10 * NT * NY + 4 - 1) tick();
    tick();
    check("beat_1004", {x, y, temp}, {5'd10, 5'd0, 4'd4});
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_idle("abort_mid");
    push_range(0, TOTAL - 2);
    do_start();
    repeat (TOTAL - 1) tick();
    check("final_beat_xzero", {x_zero, x, y, temp}, {1'b1, 5'(XL), 5'(YL), 4'(TL)});
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_idle("abort_final");
    repeat (3) tick();
    check_idle("abort_final_no_done");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/layer_3_scan_controller.md
LAYER_3_SCAN_CONTROLLER -- requirements
Module: layer_3_scan_controller

Interface
REQ-001 Parameter X_LAST, default 29, last x index; x wraps after this value.
REQ-002 Parameter Y_LAST, default 29, last y index; y wraps after this value.
REQ-003 Parameter T_LAST, default 8, last temp (kernel tap) index; temp wraps after this value.
REQ-004 Port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 Port rst  input  1  reset, asynchronous, active-high.
REQ-006 Port start  input  1  one-cycle request to begin a full scan; sampled in IDLE only.
REQ-007 Port ready  input  1  downstream datapath accepts the current beat.
REQ-008 Port abort  input  1  terminates the scan early; exists only when SCAN_ABORT_EN is defined.
REQ-009 Port busy  output  1  high in RUN and DONE.
REQ-010 Port valid  output  1  current x/y/temp beat is valid.
REQ-011 Port x, y  output  5 each  current output-pixel coordinates.
REQ-012 Port temp  output  4  current kernel tap index.
REQ-013 Ports temp_zero, y_zero, x_zero  output  1 each  end-of-level flags for the current beat.
REQ-014 Port done  output  1  one-cycle pulse after the final beat is accepted.

Function
REQ-015 FSM states SHALL be IDLE, RUN and DONE; transitions: IDLE->RUN on start, RUN->DONE on final-beat acceptance, DONE->IDLE unconditionally after one cycle.
REQ-016 In IDLE, valid=0, busy=0, done=0, and x=y=temp=0.
REQ-017 The first beat (x=0,y=0,temp=0) SHALL be presented with valid=1 in the cycle after start is sampled in IDLE.
REQ-018 In RUN, valid SHALL be 1, and a beat is accepted in a cycle where valid && ready.
REQ-019 While valid && !ready, x, y, temp and the zero flags SHALL be held unchanged.
REQ-020 On acceptance: temp increments; if temp==T_LAST, temp wraps to 0 and y increments; if additionally y==Y_LAST, y wraps to 0 and x increments (temp innermost, x outermost).
REQ-021 temp_zero = valid && temp==T_LAST; y_zero = temp_zero && y==Y_LAST; x_zero = y_zero && x==X_LAST (combinational from registered state).
REQ-022 The final beat is the one with x_zero=1; its acceptance moves the FSM to DONE and clears x, y and temp to 0.
REQ-023 In DONE, valid=0, busy=1 and done=1 for exactly one cycle.
REQ-024 start SHALL be ignored in RUN and DONE; a new scan requires start in IDLE.
REQ-025 A full scan SHALL accept exactly (X_LAST+1)*(Y_LAST+1)*(T_LAST+1) beats, i.e. 8100 at the defaults.
REQ-026 Counter arithmetic SHALL be unsigned at the port widths; no counter value exceeds its *_LAST parameter.

Reset
REQ-027 While rst=1, state SHALL be IDLE, with x=y=temp=0 and valid=busy=done=0, irrespective of clk.
REQ-028 Reset asserted mid-scan SHALL discard the scan with no done pulse; after release, the block waits for a new start.

Configuration
REQ-029 Macro SCAN_ABORT_EN defined: abort=1 in RUN SHALL force IDLE on the next edge, clear the counters, and suppress done; abort wins over a simultaneous acceptance, including of the final beat; abort SHALL be ignored in IDLE and DONE.
REQ-030 Macro SCAN_ABORT_EN undefined: the abort port and its logic SHALL be absent, and a scan ends only by completion or reset.

Verification
REQ-031 rst pulse, then start with ready held 1 -> valid rises next cycle; 8100 accepted beats; done high for one cycle after the beat (29,29,8); busy falls the cycle after done.
REQ-032 Random ready deassertion during a scan -> outputs stable while ready=0; beat sequence is identical to the ready=1 run; count is 8100.
REQ-033 Beat at (0,0,8) accepted -> temp_zero=1 with y_zero=0; next beat is (0,1,0). Beat at (0,29,8) -> y_zero=1; next beat is (1,0,0).
REQ-034 start pulsed during RUN and during DONE -> no effect on counters or count; a start in IDLE afterwards starts a fresh scan at (0,0,0).
REQ-035 rst asserted at beat (5,3,2) -> all outputs 0 immediately with no done pulse; start after release -> scan restarts at (0,0,0).
REQ-036 With SCAN_ABORT_EN, abort at beat (10,0,4) and also abort coincident with the final beat -> IDLE next cycle, done never asserted, counters 0.
